// File: rtl/cpld_jnr_sync.sv
// cpld_jnr_sync: clocked host address decode, address register, paged-ROM /
// shadow-RAM register shadows and slow-I/O wait-state generator for Beeb,
// B+, Electron and Master hosts.
// Optional build macro MASTER_ACCCON_EN: in Master mode the ACCCON register
// at FE34 also drives the shadow enable, taken from its X bit (bit 2).
module cpld_jnr_sync #(
    parameter int ADR_LAT_W        = 12,
    parameter int ROMSEL_W         = 4,
    parameter int SLOW_WAIT_CYCLES = 4
) (
    input  logic                 hsclk,
    input  logic                 resetb,
    input  logic [15:0]          cpu_adr,
    input  logic [7:0]           cpu_data,
    input  logic                 cpu_rnw,
    input  logic                 cpu_vda,
    input  logic [1:0]           j,
    input  logic                 lat_en,
    output logic                 dec_shadow_reg,
    output logic                 dec_rom_reg,
    output logic                 dec_fe4x,
    output logic [ADR_LAT_W-1:0] bbc_adr,
    output logic [ROMSEL_W-1:0]  romsel_q,
    output logic                 shadow_en_q,
    output logic                 cpu_rdy,
    output logic                 slow_busy
);

    typedef enum logic [1:0] {
        MODE_BEEB   = 2'b00,
        MODE_BPLUS  = 2'b01,
        MODE_ELK    = 2'b10,
        MODE_MASTER = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Counter reload: the stall lasts reload+1 cycles, ending when it reaches 0.
    localparam logic [3:0] WAIT_LOAD = 4'(SLOW_WAIT_CYCLES - 1);

    mode_e                mode;
    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADR_LAT_W-1:0] bbc_adr_q, bbc_adr_d;
    logic [ROMSEL_W-1:0]  romsel_d;
    logic                 shadow_en_d;
    logic                 shadow_bit;
    logic                 wr_ok;
    logic                 slow_start;
    logic                 unused_data;

    assign mode        = mode_e'(j);
    assign bbc_adr     = bbc_adr_q;
    // Only the ROM-select low bits and the enable bit are consumed.
    assign unused_data = ^cpu_data;

    // Host register address decode; switches immediately with the jumpers.
    always_comb begin
        dec_rom_reg = (mode == MODE_ELK) ? (cpu_adr == 16'hFE05)
                                         : (cpu_adr == 16'hFE30);
`ifdef MASTER_ACCCON_EN
        dec_shadow_reg = (cpu_adr == 16'hFE34) &&
                         ((mode == MODE_BPLUS) || (mode == MODE_MASTER));
        shadow_bit     = (mode == MODE_MASTER) ? cpu_data[2] : cpu_data[7];
`else
        dec_shadow_reg = (cpu_adr == 16'hFE34) && (mode == MODE_BPLUS);
        shadow_bit     = cpu_data[7];
`endif
        dec_fe4x = (cpu_adr[15:4] == 12'hFE4) || (cpu_adr[15:9] == 7'b1111110);
    end

    assign wr_ok      = cpu_vda && !cpu_rnw && (state_q != ST_WAIT);
    assign slow_start = cpu_vda && dec_fe4x;

    // Next-state for the address register and the two register shadows.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        bbc_adr_d   = bbc_adr_q;
        romsel_d    = romsel_q;
        shadow_en_d = shadow_en_q;
        if (lat_en) begin
            bbc_adr_d = cpu_adr[ADR_LAT_W-1:0];
        end
        if (wr_ok && dec_rom_reg) begin
            romsel_d = cpu_data[ROMSEL_W-1:0];
        end
        if (wr_ok && dec_shadow_reg) begin
            shadow_en_d = shadow_bit;
        end
    end

    // Wait FSM: next state, stall counter and CPU handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cpu_rdy   = 1'b1;
        slow_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slow_start) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                cpu_rdy   = 1'b0;
                slow_busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RELEASE: begin
                slow_busy = 1'b1;
                if (slow_start) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register for all clocked storage, cleared asynchronously.
    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            bbc_adr_q   <= '0;
            romsel_q    <= '0;
            shadow_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bbc_adr_q   <= bbc_adr_d;
            romsel_q    <= romsel_d;
            shadow_en_q <= shadow_en_d;
        end
    end

endmodule

// File: doc/cpld_jnr_sync.md
Name: cpld_jnr_sync

Overview:
- Clocked, parametrised successor to the CPLD address-decode/latch block.
- Decodes host system registers for Beeb, B+, Electron and Master modes.
- Registers the host-facing low address, and keeps shadow copies of the paged-ROM select and shadow-RAM registers.
- Stretches CPU cycles to slow I/O (FE4x, &FC/&FD pages) with a wait-state FSM.

Parameters:
- ADR_LAT_W, 12: width of registered host address (cpu_adr[ADR_LAT_W-1:0]); legal 8..16.
- ROMSEL_W, 4: width of captured paged-ROM select value; legal 1..8.
- SLOW_WAIT_CYCLES, 4: hsclk cycles cpu_rdy is held low per slow access; legal 1..15.

Ports:
- hsclk  in  1  system clock; all state on rising edge.
- resetb  in  1  asynchronous active-low reset.
- cpu_adr  in  16  CPU address.
- cpu_data  in  8  CPU write data.
- cpu_rnw  in  1  1=read, 0=write.
- cpu_vda  in  1  one-cycle strobe marking start of a valid CPU access.
- j  in  2  mode jumpers: 00 Beeb, 01 B+, 10 Elk, 11 Master.
- lat_en  in  1  address capture enable.
- dec_shadow_reg  out  1  combinational: address is the shadow-RAM register.
- dec_rom_reg  out  1  combinational: address is the paged-ROM register.
- dec_fe4x  out  1  combinational: address is FE40-FE4F or FC00-FDFF.
- bbc_adr  out  ADR_LAT_W  registered host address.
- romsel_q  out  ROMSEL_W  captured paged-ROM select.
- shadow_en_q  out  1  captured shadow-RAM enable.
- cpu_rdy  out  1  0 = stall CPU.
- slow_busy  out  1  1 while FSM not in IDLE.

Behaviour:
- Reset (resetb=0, async): bbc_adr=0, romsel_q=0, shadow_en_q=0, cpu_rdy=1, slow_busy=0, FSM=IDLE, counter=0.
- Decodes:
  - dec_rom_reg = (cpu_adr==FE05) in Elk mode, else (cpu_adr==FE30).
  - dec_shadow_reg = (cpu_adr==FE34) in B+ mode only; see optional feature.
  - dec_fe4x = cpu_adr[15:4]==FE4 or cpu_adr[15:9]==7'b1111110, in all modes.
- Address register: bbc_adr <= cpu_adr[ADR_LAT_W-1:0] on the clock edge where lat_en=1; otherwise it holds. This replaces the transparent latch; latency is 1 cycle.
- Register capture (single cycle): when cpu_vda=1, cpu_rnw=0 and FSM is IDLE or RELEASE:
  - dec_rom_reg: romsel_q <= cpu_data[ROMSEL_W-1:0].
  - dec_shadow_reg: shadow_en_q <= cpu_data[7].
  - Reads never modify state.
- Wait FSM:
  - IDLE: cpu_rdy=1. cpu_vda=1 and dec_fe4x=1 -> WAIT, counter <= SLOW_WAIT_CYCLES-1.
  - WAIT: cpu_rdy=0, slow_busy=1. Counter decrements each cycle; when counter==0 -> RELEASE. cpu_vda is ignored in WAIT.
  - RELEASE: cpu_rdy=1, slow_busy=1 for exactly one cycle. A cpu_vda in RELEASE is sampled as in IDLE: a slow access goes to WAIT (back-to-back); otherwise -> IDLE.
  - Net effect: cpu_rdy low for exactly SLOW_WAIT_CYCLES cycles, starting the cycle after the vda strobe.
- A register access that is also slow is impossible: the register addresses are outside the slow range.
- Mode change (j) mid-WAIT: the FSM completes unaffected; decodes switch immediately.
- resetb asserted mid-WAIT: immediate return to IDLE with cpu_rdy=1.

Optional Feature:
- Macro: MASTER_ACCCON_EN.
- Defined:
  - In Master mode, dec_shadow_reg also asserts for cpu_adr==FE34 (ACCCON).
  - A write there captures shadow_en_q <= cpu_data[2] (X bit), not bit 7.
  - B+ behaviour is unchanged.
- Undefined: dec_shadow_reg is 0 in Master mode and shadow_en_q never changes in Master mode.

Test Plan:
- Reset: resetb low mid-WAIT -> cpu_rdy=1, slow_busy=0, romsel_q=0, shadow_en_q=0, bbc_adr=0 immediately; hold for 2 cycles.
- Beeb mode j=00, write FE30 data 8'h0D with vda -> next edge romsel_q=4'hD.
  - Elk j=10, write FE30 -> romsel_q unchanged.
  - Write FE05 data 8'h0C -> romsel_q=4'hC.
- B+ j=01, write FE34 data 8'h80 -> shadow_en_q=1; write 8'h00 -> 0.
  - Beeb mode, write FE34 8'h80 -> shadow_en_q stays 0.
- Read FE40 with vda, SLOW_WAIT_CYCLES=4 -> cpu_rdy low exactly 4 cycles, then 1 RELEASE cycle (slow_busy=1), then IDLE.
  - Repeat at FC10 and FDFF; at FE50 -> no stall.
- Back-to-back: vda to FE41 during RELEASE -> WAIT re-entered with no IDLE cycle, cpu_rdy high for exactly one cycle between stalls.
- lat_en pulse with cpu_adr=16'hFE4A -> bbc_adr=12'hE4A one edge later; cpu_adr changes with lat_en=0 -> bbc_adr holds.
  - With MASTER_ACCCON_EN defined, j=11, write FE34 8'h04 -> shadow_en_q=1.
